// File: rtl/niossys_nios2_qsys_0_dct_capture_ctrl.sv
// Nios II OCI debug capture trace controller: packs trace symbols into words,
// double-buffers them for drain and sequences end-of-test. Option: DCT_DROP_ON_FULL_EN.
module niossys_nios2_qsys_0_dct_capture_ctrl #(
    parameter int unsigned SYM_W = 2,
    parameter int unsigned SLOTS = 15,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned OVF_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trc_enable,
    input  logic                     sym_valid,
    input  logic [SYM_W-1:0]         sym_data,
    output logic                     sym_ready,
    input  logic                     flush,
    input  logic                     end_req,
    output logic [SYM_W*SLOTS-1:0]   dct_buffer,
    output logic [CNT_W-1:0]         dct_count,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     test_ending,
    output logic                     test_has_ended,
    output logic [OVF_W-1:0]         drop_cnt
);

    localparam int unsigned WORD_W = SYM_W * SLOTS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ENDING  = 2'd2,
        ST_ENDED   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic [WORD_W-1:0]   out_word_q, out_word_d;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic                flush_pend_q, flush_pend_d;

    logic                out_free;
    logic                acc_full;
    logic                capturing;
    logic                store;
    logic                pend_eff;
    logic                xfer;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; end_req outranks a trc_enable drop
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (end_req)         state_d = ST_ENDING;
                else if (trc_enable) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (end_req)          state_d = ST_ENDING;
                else if (!trc_enable) state_d = ST_IDLE;
            end
            ST_ENDING: begin
                if (acc_cnt_q == '0 && !out_valid_q) state_d = ST_ENDED;
            end
            default: state_d = ST_ENDED;
        endcase
    end

    // Output decode
    always_comb begin
        sym_ready      = 1'b0;
        test_ending    = (state_q == ST_ENDING);
        test_has_ended = (state_q == ST_ENDED);
`ifdef DCT_DROP_ON_FULL_EN
        sym_ready      = capturing;
`else
        sym_ready      = capturing && (!acc_full || out_free);
`endif
    end

    // Accumulator, transfer and output-register datapath
    always_comb begin
        out_free  = !out_valid_q || out_ready;
        acc_full  = (acc_cnt_q == CNT_W'(SLOTS));
        capturing = (state_q == ST_CAPTURE);
        store     = capturing && sym_valid && (!acc_full || out_free);
        pend_eff  = flush_pend_q || (state_q == ST_ENDING);
        xfer      = (acc_full || (pend_eff && acc_cnt_q != '0)) && out_free;

        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        out_word_d  = out_word_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q;

        if (xfer) begin
            acc_d     = '0;
            acc_cnt_d = '0;
        end
        // A symbol accepted during a transfer starts the fresh word at slot 0
        if (store) begin
            if (xfer) begin
                acc_d[SYM_W-1:0] = sym_data;
                acc_cnt_d        = CNT_W'(1);
            end else begin
                for (int unsigned k = 0; k < SLOTS; k++) begin
                    if (acc_cnt_q == CNT_W'(k)) acc_d[k*SYM_W +: SYM_W] = sym_data;
                end
                acc_cnt_d = acc_cnt_q + CNT_W'(1);
            end
        end

        if (xfer) begin
            flush_pend_d = flush && store;
        end else begin
            flush_pend_d = flush_pend_q || (flush && (acc_cnt_q != '0 || store));
        end

        if (xfer) begin
            out_word_d  = acc_q;
            out_cnt_d   = acc_cnt_q;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_word_d  = '0;
            out_cnt_d   = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            out_word_q   <= '0;
            out_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            out_word_q   <= out_word_d;
            out_cnt_q    <= out_cnt_d;
            out_valid_q  <= out_valid_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign dct_buffer = out_word_q;
    assign dct_count  = out_cnt_q;
    assign out_valid  = out_valid_q;

`ifdef DCT_DROP_ON_FULL_EN
    logic [OVF_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             drop;

    // Saturating count of symbols lost while both buffers are full
    always_comb begin
        drop       = capturing && sym_valid && acc_full && !out_free;
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + OVF_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_niossys_nios2_qsys_0_dct_capture_ctrl.sv
// Self-checking bench for the DCT capture controller: queue-based reference model
// compared every cycle, plus directed literal checks of emitted words.
module tb_niossys_nios2_qsys_0_dct_capture_ctrl;

`ifdef DCT_DROP_ON_FULL_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, trc_enable, sym_valid, flush, end_req, out_ready;
    logic [1:0]  sym_data;
    logic        sym_ready, out_valid, test_ending, test_has_ended;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [7:0]  drop_cnt;

    niossys_nios2_qsys_0_dct_capture_ctrl dut (
        .clk(clk), .reset(reset), .trc_enable(trc_enable),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
        .flush(flush), .end_req(end_req),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .out_valid(out_valid),
        .out_ready(out_ready), .test_ending(test_ending),
        .test_has_ended(test_has_ended), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: phase 0 idle, 1 capture, 2 ending, 3 ended
    bit          m_live = 1'b0;
    int          m_phase;
    int          m_acc[$];
    bit          m_ov;
    logic [29:0] m_word;
    int          m_cnt;
    bit          m_pend;
    int          m_drop;

    always @(posedge clk) begin
        int old_n;
        bit old_ov, full, ofree, take, dropped, xfer;
        if (reset) begin
            m_live = 1'b1; m_phase = 0; m_acc.delete(); m_ov = 1'b0;
            m_word = '0; m_cnt = 0; m_pend = 1'b0; m_drop = 0;
        end else if (m_live) begin
            old_n   = m_acc.size();
            old_ov  = m_ov;
            full    = (old_n == 15);
            ofree   = !m_ov || out_ready;
            take    = (m_phase == 1) && sym_valid && (!full || ofree);
            dropped = DROP && (m_phase == 1) && sym_valid && full && !ofree;
            xfer    = (full || ((m_pend || m_phase == 2) && old_n > 0)) && ofree;
            if (xfer) begin
                m_word = '0;
                foreach (m_acc[k]) m_word = m_word | (30'(m_acc[k]) << (2 * k));
                m_cnt = old_n;
                m_ov  = 1'b1;
                m_acc.delete();
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0; m_cnt = 0;
            end
            if (take) m_acc.push_back(int'(sym_data));
            if (xfer) m_pend = flush && take;
            else if (flush && (old_n > 0 || take)) m_pend = 1'b1;
            if (dropped && m_drop < 255) m_drop++;
            case (m_phase)
                0: if (end_req) m_phase = 2; else if (trc_enable) m_phase = 1;
                1: if (end_req) m_phase = 2; else if (!trc_enable) m_phase = 0;
                2: if (old_n == 0 && !old_ov) m_phase = 3;
                default: m_phase = 3;
            endcase
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_live) begin
            chk("sym_ready", sym_ready,
                (m_phase == 1) && (DROP || m_acc.size() < 15 || !m_ov || out_ready));
            chk("out_valid", out_valid, m_ov);
            chk("dct_count", dct_count, m_ov ? m_cnt : 0);
            if (m_ov) chk("dct_buffer", dct_buffer, m_word);
            chk("test_ending", test_ending, m_phase == 2);
            chk("test_has_ended", test_has_ended, m_phase == 3);
            chk("drop_cnt", drop_cnt, m_drop);
        end
    end

    // Log of words actually drained by the sink: {count, buffer}
    logic [33:0] log_q[$];
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) log_q.push_back({dct_count, dct_buffer});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s);
        sym_valid = 1'b1;
        sym_data  = s;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sym_ready) begin
                @(posedge clk); #1;
                sym_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("send_timeout", 1, 0);
        sym_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1; tick(1); flush = 1'b0;
    endtask

    initial begin
        bit saw_end;
        reset = 1'b1; trc_enable = 1'b0; sym_valid = 1'b0; sym_data = '0;
        flush = 1'b0; end_req = 1'b0; out_ready = 1'b1;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sym_ready", sym_ready, 0);
        chk("rst_dct_count", dct_count, 0);
        chk("rst_has_ended", test_has_ended, 0);

        // Full word of k mod 4, one-cycle output pulse
        tick(1); trc_enable = 1'b1; tick(1);
        log_q.delete();
        for (int i = 0; i < 15; i++) send(2'(i % 4));
        @(negedge clk); chk("t1_not_yet", out_valid, 0);
        @(negedge clk); chk("t1_valid", out_valid, 1);
        chk("t1_buf", dct_buffer, 30'h24E4E4E4);
        chk("t1_cnt", dct_count, 15);
        @(negedge clk); chk("t1_pulse", out_valid, 0);
        tick(2);
        chk("t1_words", log_q.size(), 1);

        // Flushed partial word, then flush with empty accumulator
        log_q.delete();
        for (int i = 0; i < 5; i++) send(2'd3);
        pulse_flush();
        tick(3);
        chk("t2_words", log_q.size(), 1);
        if (log_q.size() > 0) chk("t2_word", log_q[0], {4'd5, 30'h000003FF});
        log_q.delete();
        pulse_flush();
        tick(5);
        chk("t2_empty_flush", log_q.size(), 0);

        // Backpressure: two words buffered, 31st symbol stalled or dropped
        out_ready = 1'b0;
        for (int i = 0; i < 30; i++) send((i < 15) ? 2'd1 : 2'd2);
        sym_valid = 1'b1; sym_data = 2'd3;
`ifdef DCT_DROP_ON_FULL_EN
        @(negedge clk); chk("t3_ready_high", sym_ready, 1);
        tick(1); sym_valid = 1'b0;
        @(negedge clk); chk("t3_drop_cnt", drop_cnt, 1);
`else
        tick(3);
        @(negedge clk); chk("t3_ready_low", sym_ready, 0);
`endif
        chk("t3_held_buf", dct_buffer, 30'h15555555);
        chk("t3_held_cnt", dct_count, 15);
        out_ready = 1'b1;
        tick(1); sym_valid = 1'b0;
        tick(3);
        pulse_flush();
        tick(3);
        chk("t3_words", log_q.size(), DROP ? 2 : 3);
        if (log_q.size() > 1) begin
            chk("t3_first", log_q[0], {4'd15, 30'h15555555});
            chk("t3_second", log_q[1], {4'd15, 30'h2AAAAAAA});
        end
        if (!DROP && log_q.size() > 2) chk("t3_third", log_q[2], {4'd1, 30'h3});

        // End-of-test with a 7-symbol partial word
        log_q.delete();
        for (int i = 0; i < 7; i++) send(2'(i % 4));
        end_req = 1'b1; tick(1); end_req = 1'b0;
        saw_end = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (test_ending) saw_end = 1'b1;
            if (test_has_ended) break;
        end
        chk("t4_saw_ending", saw_end, 1);
        chk("t4_has_ended", test_has_ended, 1);
        chk("t4_ending_low", test_ending, 0);
        chk("t4_words", log_q.size(), 1);
        if (log_q.size() > 0) chk("t4_word", log_q[0], {4'd7, 30'h000024E4});
        tick(1); trc_enable = 1'b0; tick(2);
        trc_enable = 1'b1; end_req = 1'b1; tick(1); end_req = 1'b0;
        tick(3);
        @(negedge clk);
        chk("t4_sticky", test_has_ended, 1);
        chk("t4_no_ready", sym_ready, 0);

        // Reset with a partial accumulator and a held output word
        tick(1); reset = 1'b1; tick(1); reset = 1'b0;
        out_ready = 1'b0; tick(1);
        for (int i = 0; i < 15; i++) send(2'd1);
        for (int i = 0; i < 9; i++) send(2'd2);
        @(negedge clk); chk("t5_pre_valid", out_valid, 1);
        tick(1); reset = 1'b1; trc_enable = 1'b0; tick(1); reset = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_cnt", dct_count, 0);
        chk("t5_buf", dct_buffer, 0);
        chk("t5_ready", sym_ready, 0);
        chk("t5_ending", {test_ending, test_has_ended}, 0);
        log_q.delete();
        out_ready = 1'b1;
        tick(1); pulse_flush(); tick(10);
        chk("t5_no_words", log_q.size(), 0);

        // Flush with the 15th symbol, 16th offered during the transfer
        trc_enable = 1'b1; tick(1);
        log_q.delete();
        for (int i = 0; i < 14; i++) send(2'd2);
        flush = 1'b1; send(2'd2); flush = 1'b0;
        send(2'd1);
        tick(3);
        chk("t6_words", log_q.size(), 1);
        if (log_q.size() > 0) chk("t6_word", log_q[0], {4'd15, 30'h2AAAAAAA});
        pulse_flush();
        tick(3);
        chk("t6_words2", log_q.size(), 2);
        if (log_q.size() > 1) chk("t6_tail", log_q[1], {4'd1, 30'h1});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
